// File: rtl/audio_dac_transmitter.sv
// Stereo I2S / left-justified DAC serialiser with a small stereo-pair FIFO.
// BCLK and DACLRCK are driven by the codec and resynchronised into clk_clk.
//
// state     | meaning
// WAIT_SYNC | after reset: DACDAT held 0, no pops, waiting for first LRCK high->low
// SHIFT     | shifting the current slot word out MSB-first, one bit per BCLK fall
// PAD       | word exhausted: drive 0 until the next LRCK transition
module audio_dac_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit I2S_MODE   = 1'b1
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          audio_interface_BCLK,
  input  logic                          audio_interface_DACLRCK,
  output logic                          audio_interface_DACDAT,
  input  logic [DATA_WIDTH-1:0]         sample_left,
  input  logic [DATA_WIDTH-1:0]         sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          underflow_clear
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int PTRW = PW + 1;
  localparam int LW   = PW + 1;
  localparam int CW   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {WAIT_SYNC, SHIFT, PAD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic lrck_s1_q, lrck_s2_q;
  logic bclk_fall, lr_cur;
  logic left_start, right_start, fifo_empty, push, pop, uf_set;

  state_t                  state_q, state_d;
  logic                    lr_prev_q, lr_prev_d;
  logic                    lr_seen_q, lr_seen_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0]   hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dacdat_q, dacdat_d;
  logic                    underflow_q, underflow_d;
  logic [PTRW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_h_q  <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
    end else begin
      bclk_s1_q <= audio_interface_BCLK;
      bclk_s2_q <= bclk_s1_q;
      bclk_h_q  <= bclk_s2_q;
      lrck_s1_q <= audio_interface_DACLRCK;
      lrck_s2_q <= lrck_s1_q;
    end
  end

  // LRCK shares the BCLK synchroniser depth, so at bclk_fall it already shows the new slot
  assign bclk_fall = bclk_h_q & ~bclk_s2_q;
  assign lr_cur    = lrck_s2_q;

  assign sample_ready           = (level_q != LW'(FIFO_DEPTH));
  assign fifo_level             = level_q;
  assign audio_interface_DACDAT = dacdat_q;
  assign underflow              = underflow_q;

  always_comb begin
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    lr_seen_d   = lr_seen_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    cnt_d       = cnt_q;
    dacdat_d    = dacdat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    pop         = 1'b0;
    uf_set      = 1'b0;
    fifo_empty  = (level_q == '0);
    push        = sample_valid && sample_ready;
    left_start  = bclk_fall && lr_seen_q && lr_prev_q && !lr_cur;
    right_start = bclk_fall && lr_seen_q && !lr_prev_q && lr_cur;

    if (bclk_fall) begin
      lr_prev_d = lr_cur;
      lr_seen_d = 1'b1;
    end

    // no bypass: a push into an empty FIFO cannot satisfy a pop in the same cycle
    if (left_start) begin
      if (fifo_empty) begin
        hold_l_d = '0;
        hold_r_d = '0;
        uf_set   = 1'b1;
      end else begin
        pop                  = 1'b1;
        {hold_l_d, hold_r_d} = mem_q[rd_ptr_q[PW-1:0]];
        rd_ptr_d             = rd_ptr_q + PTRW'(1);
      end
    end

    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = {sample_left, sample_right};
      wr_ptr_d                = wr_ptr_q + PTRW'(1);
    end

    level_d   = level_q + LW'(push) - LW'(pop);
    load_word = left_start ? hold_l_d : hold_r_q;

    if (left_start || (right_start && state_q != WAIT_SYNC)) begin
      state_d = SHIFT;
      if (I2S_MODE) begin
        dacdat_d = 1'b0;
        shift_d  = load_word;
        cnt_d    = CW'(DATA_WIDTH);
      end else begin
        dacdat_d = load_word[DATA_WIDTH-1];
        shift_d  = {load_word[DATA_WIDTH-2:0], 1'b0};
        cnt_d    = CW'(DATA_WIDTH - 1);
      end
    end else if (bclk_fall) begin
      case (state_q)
        SHIFT: begin
          dacdat_d = shift_q[DATA_WIDTH-1];
          shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = PAD;
        end
        default: dacdat_d = 1'b0;
      endcase
    end

    underflow_d = uf_set | (underflow_q & ~underflow_clear);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= WAIT_SYNC;
      lr_prev_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      lr_prev_q   <= lr_prev_d;
      lr_seen_q   <= lr_seen_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_audio_dac_transmitter.sv
// Drives one I2S and one left-justified instance with the same codec clocks and samples,
// comparing each slot's bit stream with a queue-based reference model.
module tb_audio_dac_transmitter;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          bclk    = 1'b1;
  logic          lrck    = 1'b1;
  logic [DW-1:0] s_l     = '0;
  logic [DW-1:0] s_r     = '0;
  logic          s_valid = 1'b0;
  logic          uf_clr  = 1'b0;
  logic          dat_i2s, dat_lj, rdy_i2s, rdy_lj, uf_i2s, uf_lj;
  logic [2:0]    lvl_i2s, lvl_lj;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*DW-1:0] q[$];
  bit              m_seen, m_prev, m_active, m_uf;
  int              m_pos;
  logic [DW-1:0]   m_word, m_hr;
  logic [31:0]     gi, gl, ei, el;

  always #10 clk_clk = ~clk_clk;

  audio_dac_transmitter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1'b1)) u_i2s (
    .clk_clk(clk_clk), .reset_reset_n(rst_n),
    .audio_interface_BCLK(bclk), .audio_interface_DACLRCK(lrck),
    .audio_interface_DACDAT(dat_i2s),
    .sample_left(s_l), .sample_right(s_r), .sample_valid(s_valid),
    .sample_ready(rdy_i2s), .fifo_level(lvl_i2s),
    .underflow(uf_i2s), .underflow_clear(uf_clr));

  audio_dac_transmitter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1'b0)) u_lj (
    .clk_clk(clk_clk), .reset_reset_n(rst_n),
    .audio_interface_BCLK(bclk), .audio_interface_DACLRCK(lrck),
    .audio_interface_DACDAT(dat_lj),
    .sample_left(s_l), .sample_right(s_r), .sample_valid(s_valid),
    .sample_ready(rdy_lj), .fifo_level(lvl_lj),
    .underflow(uf_lj), .underflow_clear(uf_clr));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seen = 0; m_prev = 0; m_active = 0; m_uf = 0; m_pos = 0;
    m_word = '0; m_hr = '0;
  endtask

  // one LRCK sample per BCLK fall; left start pops (or underflows), right start uses the held right word
  task automatic model_fall(input logic lr);
    if (!m_seen) begin
      m_seen = 1; m_prev = lr;
    end else if (m_prev != lr) begin
      m_prev = lr;
      if (!lr) begin
        if (q.size() > 0) {m_word, m_hr} = q.pop_front();
        else begin m_word = '0; m_hr = '0; m_uf = 1; end
        m_active = 1; m_pos = 0;
      end else if (m_active) begin
        m_word = m_hr; m_pos = 0;
      end
    end
  endtask

  function automatic logic exp_bit(input logic [DW-1:0] w, input int pos, input bit i2s);
    int k;
    k = i2s ? pos - 1 : pos;
    if (k < 0 || k >= DW) return 1'b0;
    return w[DW-1-k];
  endfunction

  task automatic check_levels(input string tag);
    check_eq({tag, "_lvl_i2s"}, 32'(lvl_i2s), 32'(q.size()));
    check_eq({tag, "_lvl_lj"},  32'(lvl_lj),  32'(q.size()));
    check_eq({tag, "_rdy_i2s"}, 32'(rdy_i2s), 32'(q.size() != DEPTH));
    check_eq({tag, "_rdy_lj"},  32'(rdy_lj),  32'(q.size() != DEPTH));
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    s_l = l; s_r = r; s_valid = 1'b1;
    @(posedge clk_clk); #1;
    s_valid = 1'b0;
    if (q.size() < DEPTH) q.push_back({l, r});
    check_levels("push");
  endtask

  task automatic pulse_clear();
    uf_clr = 1'b1;
    @(posedge clk_clk); #1;
    uf_clr = 1'b0;
    m_uf = 0;
    check_eq("clr_uf_i2s", 32'(uf_i2s), 0);
    check_eq("clr_uf_lj",  32'(uf_lj),  0);
  endtask

  // one LRCK slot of nbits BCLK periods (16 clk each); DACDAT sampled at each BCLK rise
  task automatic run_slot(input logic lr, input int nbits, input int rst_at,
                          output logic [31:0] g_i2s, output logic [31:0] g_lj,
                          output logic [31:0] e_i2s, output logic [31:0] e_lj);
    g_i2s = '0; g_lj = '0; e_i2s = '0; e_lj = '0;
    for (int i = 0; i < nbits; i++) begin
      bclk = 1'b0; lrck = lr;
      model_fall(lr);
      if (i == rst_at) begin
        repeat (2) @(posedge clk_clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_dat_i2s", 32'(dat_i2s), 0);
        check_eq("rst_dat_lj",  32'(dat_lj),  0);
        check_eq("rst_lvl_i2s", 32'(lvl_i2s), 0);
        check_eq("rst_lvl_lj",  32'(lvl_lj),  0);
        check_eq("rst_rdy",     32'(rdy_i2s & rdy_lj), 1);
        check_eq("rst_uf",      32'(uf_i2s | uf_lj), 0);
        repeat (2) @(posedge clk_clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk_clk); #1;
      end else begin
        repeat (8) @(posedge clk_clk); #1;
      end
      bclk = 1'b1;
      g_i2s = {g_i2s[30:0], dat_i2s};
      g_lj  = {g_lj[30:0],  dat_lj};
      e_i2s = {e_i2s[30:0], m_active ? exp_bit(m_word, m_pos, 1'b1) : 1'b0};
      e_lj  = {e_lj[30:0],  m_active ? exp_bit(m_word, m_pos, 1'b0) : 1'b0};
      if (m_active) m_pos++;
      repeat (8) @(posedge clk_clk); #1;
    end
  endtask

  task automatic check_slot(input string tag);
    check_eq({tag, "_i2s"}, gi, ei);
    check_eq({tag, "_lj"},  gl, el);
  endtask

  task automatic run_frame(input int nbits, input string tag);
    run_slot(1'b0, nbits, -1, gi, gl, ei, el);
    check_slot({tag, "_L"});
    run_slot(1'b1, nbits, -1, gi, gl, ei, el);
    check_slot({tag, "_R"});
    check_eq({tag, "_uf_i2s"}, 32'(uf_i2s), 32'(m_uf));
    check_eq({tag, "_uf_lj"},  32'(uf_lj),  32'(m_uf));
    check_levels(tag);
  endtask

  initial begin
    int c;
    int nb;
    logic [DW-1:0] l5, r5;

    model_reset();
    repeat (3) @(posedge clk_clk); #1;
    check_eq("reset_dat",  32'({dat_i2s, dat_lj}), 0);
    check_eq("reset_uf",   32'({uf_i2s, uf_lj}), 0);
    check_levels("reset");
    rst_n = 1'b1;
    @(posedge clk_clk); #1;

    // prime the LRCK history with a right-slot sample
    run_slot(1'b1, 2, -1, gi, gl, ei, el);
    check_slot("prime");

    // basic frame, also against the literal expected streams
    push_pair(16'hA5C3, 16'h0F0F);
    run_slot(1'b0, 32, -1, gi, gl, ei, el);
    check_slot("basic_L");
    check_eq("basic_L_lit_i2s", gi, {1'b0, 16'hA5C3, 15'b0});
    check_eq("basic_L_lit_lj",  gl, {16'hA5C3, 16'h0});
    check_levels("basic_mid");
    run_slot(1'b1, 32, -1, gi, gl, ei, el);
    check_slot("basic_R");
    check_eq("basic_R_lit_i2s", gi, {1'b0, 16'h0F0F, 15'b0});
    check_eq("basic_R_lit_lj",  gl, {16'h0F0F, 16'h0});
    check_eq("basic_uf", 32'(uf_i2s | uf_lj), 0);

    // underflow: empty FIFO at left start
    run_frame(32, "uflow");
    check_eq("uflow_set", 32'(uf_i2s & uf_lj), 1);
    pulse_clear();
    // clear held across the cycle underflow is set: set must win
    fork
      run_slot(1'b0, 32, -1, gi, gl, ei, el);
      begin
        wait (bclk == 1'b0);
        uf_clr = 1'b1;
        repeat (3) @(posedge clk_clk); #1;
        uf_clr = 1'b0;
      end
    join
    check_slot("uf_coinc_L");
    check_eq("uf_coinc_i2s", 32'(uf_i2s), 1);
    check_eq("uf_coinc_lj",  32'(uf_lj),  1);
    run_slot(1'b1, 32, -1, gi, gl, ei, el);
    check_slot("uf_coinc_R");
    pulse_clear();

    // full FIFO with a held 5th pair
    for (int i = 0; i < DEPTH; i++) push_pair(DW'($urandom), DW'($urandom));
    l5 = DW'($urandom); r5 = DW'($urandom);
    s_l = l5; s_r = r5; s_valid = 1'b1;
    repeat (5) @(posedge clk_clk); #1;
    check_eq("full_lvl",  32'(lvl_i2s), DEPTH);
    check_eq("full_rdy",  32'(rdy_i2s | rdy_lj), 0);
    c = 0;
    fork
      run_slot(1'b0, 32, -1, gi, gl, ei, el);
      begin
        wait (bclk == 1'b0);
        while (!rdy_i2s && c < 6) begin
          @(posedge clk_clk); #1;
          c++;
        end
        if (rdy_i2s) begin
          @(posedge clk_clk); #1;
          q.push_back({l5, r5});
        end
        s_valid = 1'b0;
      end
    join
    check_eq("full_ready_lat", 32'(c <= 4), 1);
    check_slot("full_L");
    check_levels("full_after");
    check_eq("full_lvl4", 32'(lvl_i2s), DEPTH);
    run_slot(1'b1, 32, -1, gi, gl, ei, el);
    check_slot("full_R");
    for (int i = 0; i < DEPTH; i++) run_frame(32, "drain");

    // short slots: 12 BCLKs per slot
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    run_frame(12, "short1");
    run_frame(12, "short2");

    // randomized frames, pushes and slot lengths
    for (int f = 0; f < 8; f++) begin
      for (int p = $urandom_range(0, 2); p > 0; p--) push_pair(DW'($urandom), DW'($urandom));
      case ($urandom_range(0, 3))
        0:       nb = 12;
        1:       nb = 17;
        2:       nb = 24;
        default: nb = 32;
      endcase
      run_frame(nb, "rand");
      if (m_uf && $urandom_range(0, 1) == 1) pulse_clear();
    end

    // reset during left-slot bit 7
    push_pair(16'h1234, 16'h5678);
    push_pair(16'h9ABC, 16'hDEF0);
    run_slot(1'b0, 32, 7, gi, gl, ei, el);
    check_slot("rst_L");
    run_slot(1'b1, 32, -1, gi, gl, ei, el);
    check_slot("rst_R");
    check_eq("rst_R_zero", gi | gl, 0);
    check_levels("rst_after");
    push_pair(16'hC001, 16'h8E11);
    run_slot(1'b0, 32, -1, gi, gl, ei, el);
    check_slot("post_rst_L");
    check_eq("post_rst_L_lit", gi, {1'b0, 16'hC001, 15'b0});
    run_slot(1'b1, 32, -1, gi, gl, ei, el);
    check_slot("post_rst_R");
    check_eq("post_rst_R_lit", gl, {16'h8E11, 16'h0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_dac_transmitter.md
Name: audio_dac_transmitter

Overview:
- I2S/left-justified serial transmitter for the codec DAC path; the playback counterpart of the existing ADC capture interface (ADCDAT/ADCLRCK/BCLK).
- Codec is bus master: the block receives BCLK and DACLRCK from the codec and drives DACDAT.
- Stereo sample pairs arrive from the processor/Avalon side over a valid/ready handshake, are buffered in a small FIFO, and are serialised MSB-first, one pair per LRCK frame.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- FIFO_DEPTH, 4, stereo-pair entries; must be a power of 2, at least 2.
- I2S_MODE, 1, 1 = I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on the LRCK edge).

Ports:
- clk_clk  in  1  system clock, 50 MHz; must be at least 8x BCLK.
- reset_reset_n  in  1  asynchronous, active-low reset.
- audio_interface_BCLK  in  1  codec bit clock, asynchronous to clk_clk.
- audio_interface_DACLRCK  in  1  codec DAC LR clock; low = left slot, high = right slot.
- audio_interface_DACDAT  out  1  serial DAC data.
- sample_left  in  DATA_WIDTH  left sample, two's complement.
- sample_right  in  DATA_WIDTH  right sample.
- sample_valid  in  1  producer has a pair.
- sample_ready  out  1  FIFO can accept.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- underflow  out  1  sticky; a frame was started with the FIFO empty.
- underflow_clear  in  1  single-cycle clear of underflow.

Behaviour:
- Reset values: DACDAT=0, fifo_level=0, sample_ready=1, underflow=0, FSM=WAIT_SYNC, shift register and holding registers = 0.
- Synchronisers: BCLK and DACLRCK each pass through a 2-flop synchroniser plus one history flop.
  - A BCLK falling edge (bclk_fall) is detected from the synchronised signals.
  - LRCK is sampled only on bclk_fall, into lr_cur and lr_prev.
- Output timing: DACDAT changes only in the clk_clk cycle after bclk_fall is detected, no later than 4 clk_clk cycles after the physical BCLK fall. The codec samples on BCLK rise.
- Push: a pair is written when sample_valid && sample_ready. sample_ready = (fifo_level != FIFO_DEPTH), registered-free.
- Pop: on a left-frame start only (see below). Push and pop may occur in the same cycle.
  - Level is unchanged.
  - An empty FIFO does not bypass: a pop on empty counts as underflow even if a push occurs that cycle.
- FSM:
  - WAIT_SYNC: DACDAT held 0; no pops. The first LRCK sample after reset only initialises lr_prev. Go to SHIFT on the first high->low LRCK transition (left start).
  - SHIFT, left start (lr_prev=1, lr_cur=0):
    - If the FIFO is non-empty, pop the pair into hold_l/hold_r. If empty, load zeros and set underflow.
    - Load shift register with hold_l. Set bit counter to DATA_WIDTH.
  - SHIFT, right start (0->1): load shift register with hold_r; set bit counter to DATA_WIDTH.
  - SHIFT, each bclk_fall: emit the next bit MSB-first.
    - I2S_MODE=0: the MSB is driven on the same bclk_fall that detects the transition.
    - I2S_MODE=1: that bclk_fall drives 0 (or the previous slot's pad); the MSB follows on the next bclk_fall.
    - The counter decrements per emitted bit. At 0, go to PAD.
  - PAD: DACDAT=0 on every bclk_fall until the next LRCK transition, which reloads as above and returns to SHIFT.
- Short slot (fewer BCLKs than DATA_WIDTH): the LRCK transition aborts the current word. Remaining LSBs are dropped and the new slot starts cleanly.
- Long slot: zero padding, per PAD.
- underflow: set has priority over underflow_clear in the same cycle. It is cleared only by underflow_clear or reset.
- Reset asserted at any point (including mid-slot): all outputs return to reset values immediately, the FIFO contents are discarded, and the block resynchronises via WAIT_SYNC.
- fifo_level is updated in the cycle after the push/pop edge. Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.

Test Plan:
- Basic I2S frame. Setup: BCLK 3.125 MHz (16 clk_clk), LRCK = BCLK/64, I2S_MODE=1. Push L=16'hA5C3, R=16'h0F0F. Required: left slot = 0, then 1010010111000011, then 15 zeros; right slot = 0, then 0000111100001111, then zeros. fifo_level goes 1->0; underflow stays 0.
- Underflow. Stimulus: empty FIFO at a left start. Required: the whole frame is 0 and underflow=1. An underflow_clear pulse drops it to 0; a clear coincident with a new underflow leaves it at 1.
- Full FIFO. Stimulus: push 4 pairs with no frames running. Required: fifo_level=4 and sample_ready=0; a held 5th valid is not accepted. After the next left start, sample_ready=1 within 2 clk_clk cycles and the 5th pair is accepted; fifo_level reads 4.
- Left-justified mode. Stimulus: I2S_MODE=0, same data as the first test. Required: the MSB (1) appears on the bclk_fall coincident with the LRCK fall, followed by 15 data bits then 16 zeros.
- Reset mid-slot. Stimulus: assert reset_reset_n=0 during left-slot bit 7. Required: DACDAT=0 and fifo_level=0 immediately. After release, DACDAT stays 0 through the rest of the frame; the first frame after the next LRCK fall carries the newly pushed pair correctly.
- Short slot. Stimulus: LRCK = BCLK/24 (12 BCLKs/slot), DATA_WIDTH=16, I2S. Required: only the top 11 bits of each sample are emitted, and the next slot starts with its own MSB with no carry-over.
